// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS front-end pipeline registers: next-PC select
// encodings, reset defaults and bit positions within the decoded control bundle.
package pipe_pkg;

    typedef enum logic [1:0] {
        PCSRC_PC4    = 2'd0,
        PCSRC_BRANCH = 2'd1,
        PCSRC_JUMP   = 2'd2,
        PCSRC_JR     = 2'd3
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;
    localparam int          DEFAULT_CTRL_W   = 16;
    localparam int          DEFAULT_CNT_W    = 16;

    // Control bundle layout produced by the decoder.
    localparam int CTRL_REGWRITE_BIT = 0;
    localparam int CTRL_MEMTOREG_BIT = 1;
    localparam int CTRL_MEMWRITE_BIT = 2;
    localparam int CTRL_MEMREAD_BIT  = 3;
    localparam int CTRL_ALUSRC_BIT   = 4;
    localparam int CTRL_REGDST_BIT   = 5;

endpackage

// File: rtl/pipe_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous reset.
module pipe_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_front.sv
// PC, IF/ID and ID/EX registers of the five-stage core, steered by the hazard
// unit's stall/flush controls, plus stall and bubble event counters.
module pipe_front
    import pipe_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          CTRL_W      = DEFAULT_CTRL_W,
    parameter int          MEMREAD_BIT = CTRL_MEMREAD_BIT,
    parameter int          CNT_W       = DEFAULT_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              IFWrite,
    input  logic              ID_Write,
    input  logic              ID_Flush,
    input  logic              EX_Flush,
    input  logic [1:0]        PCSrc,
    input  logic [31:0]       BranchTarget,
    input  logic [31:0]       JumpTarget,
    input  logic [31:0]       JrTarget,
    output logic [31:0]       IF_PC,
    input  logic [31:0]       IF_Instr,
    output logic [31:0]       ID_Instr,
    output logic [31:0]       ID_PC4,
    output logic              ID_Valid,
    input  logic [CTRL_W-1:0] ID_Ctrl,
    input  logic [31:0]       ID_DataA,
    input  logic [31:0]       ID_DataB,
    input  logic [31:0]       ID_Imm,
    input  logic [4:0]        ID_rs,
    input  logic [4:0]        ID_rt,
    input  logic [4:0]        ID_rd,
    output logic [CTRL_W-1:0] EX_Ctrl,
    output logic [31:0]       EX_DataA,
    output logic [31:0]       EX_DataB,
    output logic [31:0]       EX_Imm,
    output logic [31:0]       EX_PC4,
    output logic [4:0]        EX_rs,
    output logic [4:0]        EX_rt,
    output logic [4:0]        EX_rd,
    output logic              EX_Valid,
    output logic              EX_MemRead,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    assign pc_plus4 = IF_PC + 32'd4;

    // NOTE: next_pc gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        next_pc = pc_plus4;
        unique case (pcsrc_e'(PCSrc))
            PCSRC_PC4:    next_pc = pc_plus4;
            PCSRC_BRANCH: next_pc = BranchTarget;
            PCSRC_JUMP:   next_pc = JumpTarget;
            PCSRC_JR:     next_pc = JrTarget;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            IF_PC <= RESET_PC;
        end else if (IFWrite) begin
            IF_PC <= next_pc;
        end
    end

    // A flush squashes the slot even while ID_Write is low (jump squashing a held slot).
    always_ff @(posedge clk) begin
        if (reset || ID_Flush) begin
            ID_Instr <= NOP_INSTR;
            ID_PC4   <= '0;
            ID_Valid <= 1'b0;
        end else if (ID_Write) begin
            ID_Instr <= IF_Instr;
            ID_PC4   <= pc_plus4;
            ID_Valid <= 1'b1;
        end
    end

    // ID/EX never holds; a bubble zeroes rt and MemRead so it cannot re-trigger load-use.
    always_ff @(posedge clk) begin
        if (reset || EX_Flush) begin
            EX_Ctrl  <= '0;
            EX_DataA <= '0;
            EX_DataB <= '0;
            EX_Imm   <= '0;
            EX_PC4   <= '0;
            EX_rs    <= '0;
            EX_rt    <= '0;
            EX_rd    <= '0;
            EX_Valid <= 1'b0;
        end else begin
            EX_Ctrl  <= ID_Ctrl;
            EX_DataA <= ID_DataA;
            EX_DataB <= ID_DataB;
            EX_Imm   <= ID_Imm;
            EX_PC4   <= ID_PC4;
            EX_rs    <= ID_rs;
            EX_rt    <= ID_rt;
            EX_rd    <= ID_rd;
            EX_Valid <= ID_Valid;
        end
    end

    assign EX_MemRead = EX_Ctrl[MEMREAD_BIT];

    pipe_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (~IFWrite),
        .count (stall_cnt)
    );

    pipe_sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (EX_Flush),
        .count (bubble_cnt)
    );

endmodule

// File: doc/pipe_front.md
# pipe_front

Front-end pipeline register block for the five-stage MIPS core: PC register, IF/ID register and ID/EX register, all driven by the stall/flush controls from the hazard unit. It is the consumer side of the hazard interface. It acts on `IFWrite`, `ID_Write`, `ID_Flush` and `EX_Flush`, and returns `EX_rt`/`EX_MemRead` to the hazard unit. Two saturating event counters (stall cycles, bubbles) are kept for performance debug.

## Interface
- `RESET_PC`, 32'h8000_0000, PC value after reset
- `CTRL_W`, 16, width of decoded control bundle
- `MEMREAD_BIT`, 3, index of MemRead within control bundle
- `CNT_W`, 16, event counter width
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `IFWrite`, `ID_Write`, `ID_Flush`, `EX_Flush`  in  1 each  hazard-unit controls
- `PCSrc`  in  2  next-PC select: 0 PC+4, 1 branch, 2 jump, 3 jr
- `BranchTarget`, `JumpTarget`, `JrTarget`  in  32 each  candidate PCs
- `IF_PC`  out  32  current fetch address to instruction memory
- `IF_Instr`  in  32  instruction read at `IF_PC` (same cycle)
- `ID_Instr`, `ID_PC4`  out  32  IF/ID contents
- `ID_Valid`  out  1  IF/ID holds a real instruction
- `ID_Ctrl`  in  CTRL_W  decoded control
- `ID_DataA`, `ID_DataB`, `ID_Imm`  in  32  operands
- `ID_rs`, `ID_rt`, `ID_rd`  in  5  register numbers
- `EX_Ctrl`  out  CTRL_W; `EX_DataA`, `EX_DataB`, `EX_Imm`, `EX_PC4`  out  32; `EX_rs`, `EX_rt`, `EX_rd`  out  5; `EX_Valid`  out  1  ID/EX contents
- `EX_MemRead`  out  1  `EX_Ctrl[MEMREAD_BIT]`, to hazard unit
- `stall_cnt`, `bubble_cnt`  out  CNT_W  event counters

## Operation
- PC: `IFWrite`=1 → load next-PC per `PCSrc`; `IFWrite`=0 → hold. PC+4 computed mod 2^32 (0xFFFF_FFFC+4 = 0).
- IF/ID, priority order:
  - `ID_Flush`=1 → `ID_Instr`=0 (nop), `ID_PC4`=0, `ID_Valid`=0. This takes priority even when `ID_Write`=0, the jump case.
  - else `ID_Write`=1 → load `IF_Instr`, `IF_PC`+4; `ID_Valid`=1.
  - else hold.
- ID/EX:
  - `EX_Flush`=1 → all fields 0 and `EX_Valid`=0. This yields `EX_rt`=0 and `EX_MemRead`=0, so a bubble never re-triggers load-use.
  - else load all `ID_*` fields and `ID_PC4`, with `EX_Valid`=`ID_Valid`. There is no hold state; ID/EX always advances.
- `ID_Flush` and `EX_Flush` together: both applied independently.
- Counters:
  - `stall_cnt` increments on every cycle with `IFWrite`=0.
  - `bubble_cnt` increments on every cycle with `EX_Flush`=1.
  - Both saturate at all-ones and never wrap.
- `EX_MemRead` is purely combinational from the ID/EX register. No other combinational input→output paths except `IF_PC`-independent wiring.

## Timing
- All state updates on rising `clk`. Controls sampled in the same edge they are presented.
- Reset (synchronous, dominates all controls): `IF_PC`=RESET_PC; all IF/ID and ID/EX outputs 0; `ID_Valid`=`EX_Valid`=0; counters 0.
- Latency:
  - Instruction at `IF_PC` in cycle n appears on `ID_Instr` in n+1 and in ID/EX in n+2, absent stalls.
  - A load-use stall (IFWrite=ID_Write=0, EX_Flush=1 for one cycle) adds exactly one cycle, with one bubble in EX.
- Jump: `ID_Flush`=1 with `IFWrite`=1 → PC takes the target and the slot following the jump is squashed the next cycle.
- Reset mid-stall: reset wins; controls in that cycle are ignored and counters clear.

## Structure
- Shared package `pipe_pkg`: `PCSRC_*` encodings (2-bit), `NOP_INSTR`=32'h0, `RESET_PC` default, control-bundle bit indices including `MEMREAD_BIT`.
- One sub-module, `pipe_sat_counter` (width param, `inc` input, synchronous reset), instantiated twice.
- Registers are otherwise flat in `pipe_front`.

## Test plan
- Reset: assert `reset` 2 cycles with all controls at 1 → `IF_PC`=0x8000_0000, `ID_Valid`=0, `EX_Valid`=0, counters 0.
- Free run: `IF_Instr`=0x2008_0005 at PC 0x8000_0000, controls = 1/1/0/0, `PCSrc`=0 → next cycle `ID_Instr`=0x2008_0005, `ID_PC4`=0x8000_0004, `IF_PC`=0x8000_0004.
- Load-use: `IFWrite`=`ID_Write`=0, `EX_Flush`=1 for one cycle → PC and IF/ID unchanged; `EX_Valid`=0, `EX_rt`=0, `EX_MemRead`=0; `stall_cnt`=1, `bubble_cnt`=1.
- Jump: `ID_Flush`=1, `ID_Write`=0, `IFWrite`=1, `PCSrc`=2, `JumpTarget`=0x8000_0100 → `IF_PC`=0x8000_0100, `ID_Instr`=0, `ID_Valid`=0.
- Wrap/saturation: PC 0xFFFF_FFFC with `PCSrc`=0 → `IF_PC`=0. Holding `IFWrite`=0 for 65 540 cycles → `stall_cnt`=0xFFFF.
- Reset during stall: `reset`=1 while `IFWrite`=0 and `EX_Flush`=1 → all reset values next cycle, counters 0.
